// File: rtl/jk_bank_arbiter.sv
// jk_bank_arbiter: two-requester round-robin arbiter in front of a bank of
// JK cells. An accepted command drives J/K onto one cell for cnt+1 cycles
// and then pulses done with the id of the requester it belonged to.
module jk_bank_arbiter #(
  parameter int NCELLS = 8,
  parameter int CNTW   = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       req0_valid,
  output logic                       req0_ready,
  input  logic [1:0]                 req0_cmd,
  input  logic [$clog2(NCELLS)-1:0]  req0_idx,
  input  logic [CNTW-1:0]            req0_cnt,
  input  logic                       req1_valid,
  output logic                       req1_ready,
  input  logic [1:0]                 req1_cmd,
  input  logic [$clog2(NCELLS)-1:0]  req1_idx,
  input  logic [CNTW-1:0]            req1_cnt,
  output logic [NCELLS-1:0]          q,
  output logic                       busy,
  output logic                       done,
  output logic                       done_id
);

  localparam int IDXW = $clog2(NCELLS);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_APPLY = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic              rr;
  logic [CNTW-1:0]   cnt_r;
  logic              id_r;
  logic [1:0]        cmd_r;
  logic [IDXW-1:0]   idx_r;
  logic [NCELLS-1:0] q_r;
  logic [NCELLS-1:0] q_nxt;

  logic              grant_vld;
  logic              grant_id;
  logic              accept;
  logic [1:0]        acc_cmd;
  logic [IDXW-1:0]   acc_idx;
  logic [CNTW-1:0]   acc_cnt;

  // Standard JK cell behaviour; cmd is {J,K}.
  function automatic logic jk_next(input logic cur, input logic [1:0] jk);
    logic r;
    r = cur;
    unique case (jk)
      2'b00:   r = cur;
      2'b01:   r = 1'b0;
      2'b10:   r = 1'b1;
      2'b11:   r = ~cur;
      default: r = cur;
    endcase
    return r;
  endfunction

  // Arbitration, ready generation and next-state selection.
  always_comb begin
    state_nxt  = state;
    grant_vld  = 1'b0;
    grant_id   = 1'b0;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (req0_valid && req1_valid) begin
          grant_vld = 1'b1;
          grant_id  = rr;
        end else if (req0_valid) begin
          grant_vld = 1'b1;
          grant_id  = 1'b0;
        end else if (req1_valid) begin
          grant_vld = 1'b1;
          grant_id  = 1'b1;
        end
        // Gating with rst_n keeps ready low for the whole reset window,
        // not only from the next edge on.
        req0_ready = rst_n && grant_vld && !grant_id;
        req1_ready = rst_n && grant_vld &&  grant_id;
        if (grant_vld) state_nxt = S_APPLY;
      end
      S_APPLY: begin
        if (cnt_r == '0) state_nxt = S_DONE;
      end
      S_DONE: begin
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // The winner's command fields, selected for latching on accept.
  always_comb begin
    accept  = (state == S_IDLE) && grant_vld;
    acc_cmd = grant_id ? req1_cmd : req0_cmd;
    acc_idx = grant_id ? req1_idx : req0_idx;
    acc_cnt = grant_id ? req1_cnt : req0_cnt;
  end

  // Next value of the cell bank: only the addressed cell moves, and only in APPLY.
  always_comb begin
    q_nxt = q_r;
    for (int i = 0; i < NCELLS; i++) begin
      if ((state == S_APPLY) && (idx_r == IDXW'(i))) begin
        q_nxt[i] = jk_next(q_r[i], cmd_r);
      end
    end
  end

  // Control state: FSM, round-robin pointer, repeat counter, owner id and cells.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      rr    <= 1'b0;
      cnt_r <= '0;
      id_r  <= 1'b0;
      q_r   <= '0;
    end else begin
      state <= state_nxt;
      q_r   <= q_nxt;
      if (accept) begin
        rr    <= ~grant_id;
        id_r  <= grant_id;
        cnt_r <= acc_cnt;
      end else if ((state == S_APPLY) && (cnt_r != '0)) begin
        // Counting down to zero (not past it) gives exactly cnt+1 applications,
        // so an all-ones count never wraps.
        cnt_r <= cnt_r - 1'b1;
      end
    end
  end

  // Latched command payload; only meaningful while a command is active.
  always_ff @(posedge clk) begin
    if (accept) begin
      cmd_r <= acc_cmd;
      idx_r <= acc_idx;
    end
  end

  assign q       = q_r;
  assign busy    = (state != S_IDLE);
  assign done    = (state == S_DONE);
  assign done_id = (state == S_DONE) && id_r;

endmodule

// File: tb/tb_jk_bank_arbiter.sv
// Testbench for jk_bank_arbiter: directed vector table, hand-written
// multi-cycle sequences and randomized transactions against a
// transaction-level model.
module tb_jk_bank_arbiter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       req0_valid, req1_valid;
  logic       req0_ready, req1_ready;
  logic [1:0] req0_cmd, req1_cmd;
  logic [2:0] req0_idx, req1_idx;
  logic [3:0] req0_cnt, req1_cnt;
  logic [7:0] q;
  logic       busy, done, done_id;

  int         checks = 0;
  int         errors = 0;
  logic       rr_m;
  logic [7:0] q_m;

  jk_bank_arbiter #(.NCELLS(8), .CNTW(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_cmd(req0_cmd),
    .req0_idx(req0_idx), .req0_cnt(req0_cnt),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_cmd(req1_cmd),
    .req1_idx(req1_idx), .req1_cnt(req1_cnt),
    .q(q), .busy(busy), .done(done), .done_id(done_id)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       v0; logic [1:0] c0; logic [2:0] i0; logic [3:0] n0;
    logic       v1; logic [1:0] c1; logic [2:0] i1; logic [3:0] n1;
    int         w;
    logic [7:0] eq;
  } vec_t;

  vec_t tbl[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Final cell state after a whole command: a function of cmd and the
  // number of applications (cnt+1), not of cycle-level behaviour.
  function automatic logic [7:0] jk_model(input logic [7:0] qi, input logic [1:0] c,
                                          input logic [2:0] ix, input logic [3:0] n);
    logic [7:0] r;
    r = qi;
    case (c)
      2'b01:   r[ix] = 1'b0;
      2'b10:   r[ix] = 1'b1;
      2'b11:   if (((int'(n) + 1) % 2) == 1) r[ix] = ~r[ix];
      default: r = qi;
    endcase
    return r;
  endfunction

  // Entered and left at posedge+1. w = expected winner (-1: none).
  task automatic run_txn(input logic v0, input logic [1:0] c0, input logic [2:0] i0,
                         input logic [3:0] n0, input logic v1, input logic [1:0] c1,
                         input logic [2:0] i1, input logic [3:0] n1,
                         input int w, input logic [7:0] eq);
    logic [7:0] mask;
    logic [7:0] qb;
    logic [3:0] n;
    logic [2:0] ix;
    int         lat;
    qb = q_m;
    req0_valid = v0; req0_cmd = c0; req0_idx = i0; req0_cnt = n0;
    req1_valid = v1; req1_cmd = c1; req1_idx = i1; req1_cnt = n1;
    #1;
    chk("ready0", 32'(req0_ready), 32'(w == 0));
    chk("ready1", 32'(req1_ready), 32'(w == 1));
    if (w < 0) begin
      @(posedge clk); #1;
      chk("idle_busy", 32'(busy), 32'(0));
      chk("idle_q", 32'(q), 32'(qb));
      req0_valid = 1'b0; req1_valid = 1'b0;
    end else begin
      n    = (w == 0) ? n0 : n1;
      ix   = (w == 0) ? i0 : i1;
      mask = 8'd1 << ix;
      rr_m = (w == 0);
      @(posedge clk); #1;
      lat = 0;
      while (!done && lat < 40) begin
        chk("apply_busy", 32'(busy), 32'(1));
        chk("apply_ready", 32'({req0_ready, req1_ready}), 32'(0));
        chk("untouched", 32'(q & ~mask), 32'(qb & ~mask));
        @(posedge clk); #1;
        lat++;
      end
      chk("latency", 32'(lat), 32'(n) + 32'd1);
      chk("final_q", 32'(q), 32'(eq));
      chk("done_id", 32'(done_id), 32'(w[0]));
      chk("done_busy", 32'(busy), 32'(1));
      q_m = eq;
      req0_valid = 1'b0; req1_valid = 1'b0;
      @(posedge clk); #1;
      chk("done_pulse", 32'(done), 32'(0));
      chk("after_busy", 32'(busy), 32'(0));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic       v0, v1;
    logic [1:0] c0, c1;
    logic [2:0] i0, i1;
    logic [3:0] n0, n1;
    int         w;
    logic [7:0] eq;

    tbl[0] = '{1'b1, 2'b10, 3'd3, 4'd0,  1'b0, 2'b00, 3'd0, 4'd0,  0, 8'h08};
    tbl[1] = '{1'b0, 2'b00, 3'd0, 4'd0,  1'b1, 2'b11, 3'd0, 4'd2,  1, 8'h09};
    tbl[2] = '{1'b1, 2'b11, 3'd0, 4'd1,  1'b0, 2'b00, 3'd0, 4'd0,  0, 8'h09};
    tbl[3] = '{1'b0, 2'b00, 3'd0, 4'd0,  1'b1, 2'b10, 3'd7, 4'd15, 1, 8'h89};
    tbl[4] = '{1'b1, 2'b01, 3'd3, 4'd4,  1'b0, 2'b00, 3'd0, 4'd0,  0, 8'h81};
    tbl[5] = '{1'b0, 2'b00, 3'd0, 4'd0,  1'b1, 2'b00, 3'd2, 4'd1,  1, 8'h81};
    tbl[6] = '{1'b1, 2'b10, 3'd5, 4'd0,  1'b0, 2'b00, 3'd0, 4'd0,  0, 8'hA1};
    tbl[7] = '{1'b0, 2'b00, 3'd0, 4'd0,  1'b1, 2'b01, 3'd7, 4'd0,  1, 8'h21};

    // Reset with both requesters asking: nothing may be granted.
    rst_n = 1'b0;
    req0_valid = 1'b1; req0_cmd = 2'b10; req0_idx = 3'd1; req0_cnt = 4'd0;
    req1_valid = 1'b1; req1_cmd = 2'b10; req1_idx = 3'd2; req1_cnt = 4'd0;
    #12;
    chk("rst_q", 32'(q), 32'(0));
    chk("rst_busy", 32'(busy), 32'(0));
    chk("rst_done", 32'(done), 32'(0));
    chk("rst_done_id", 32'(done_id), 32'(0));
    chk("rst_ready", 32'({req0_ready, req1_ready}), 32'(0));
    @(posedge clk); #1;
    chk("rst_held_q", 32'(q), 32'(0));
    req0_valid = 1'b0; req1_valid = 1'b0;
    rst_n = 1'b1;
    q_m = 8'h00; rr_m = 1'b0;

    // Directed single-requester commands.
    for (int k = 0; k < 8; k++) begin
      run_txn(tbl[k].v0, tbl[k].c0, tbl[k].i0, tbl[k].n0,
              tbl[k].v1, tbl[k].c1, tbl[k].i1, tbl[k].n1, tbl[k].w, tbl[k].eq);
    end

    // Continuous contention with rr=0: grants alternate 0,1,0,1.
    run_txn(1'b1, 2'b10, 3'd1, 4'd0, 1'b1, 2'b11, 3'd6, 4'd0, 0, 8'h23);
    run_txn(1'b1, 2'b10, 3'd1, 4'd0, 1'b1, 2'b11, 3'd6, 4'd0, 1, 8'h63);
    run_txn(1'b1, 2'b10, 3'd1, 4'd0, 1'b1, 2'b11, 3'd6, 4'd0, 0, 8'h63);
    run_txn(1'b1, 2'b10, 3'd1, 4'd0, 1'b1, 2'b11, 3'd6, 4'd0, 1, 8'h23);

    // Fill the bank, then RESET idx 7 with maximum count.
    for (int i = 0; i < 8; i++) begin
      run_txn(1'b1, 2'b10, 3'(i), 4'd0, 1'b0, 2'b00, 3'd0, 4'd0, 0, q_m | (8'd1 << i));
    end
    chk("filled", 32'(q), 32'hFF);
    run_txn(1'b1, 2'b01, 3'd7, 4'd15, 1'b0, 2'b00, 3'd0, 4'd0, 0, 8'h7F);

    // Reach 8'h55, then HOLD idx 2 for two cycles.
    run_txn(1'b0, 2'b00, 3'd0, 4'd0, 1'b1, 2'b01, 3'd1, 4'd0, 1, 8'h7D);
    run_txn(1'b0, 2'b00, 3'd0, 4'd0, 1'b1, 2'b01, 3'd3, 4'd0, 1, 8'h75);
    run_txn(1'b0, 2'b00, 3'd0, 4'd0, 1'b1, 2'b01, 3'd5, 4'd0, 1, 8'h55);
    run_txn(1'b1, 2'b00, 3'd2, 4'd1, 1'b0, 2'b00, 3'd0, 4'd0, 0, 8'h55);

    // Reset in the middle of a long TOGGLE: aborted, no done pulse.
    req0_valid = 1'b1; req0_cmd = 2'b11; req0_idx = 3'd4; req0_cnt = 4'd15;
    req1_valid = 1'b0;
    #1;
    chk("abort_ready0", 32'(req0_ready), 32'(1));
    @(posedge clk); #1;
    repeat (5) begin @(posedge clk); #1; end
    chk("abort_busy_pre", 32'(busy), 32'(1));
    rst_n = 1'b0;
    #1;
    chk("abort_q", 32'(q), 32'(0));
    chk("abort_busy", 32'(busy), 32'(0));
    chk("abort_done", 32'(done), 32'(0));
    chk("abort_ready", 32'({req0_ready, req1_ready}), 32'(0));
    repeat (3) begin
      @(posedge clk); #1;
      chk("abort_no_done", 32'(done), 32'(0));
      chk("abort_idle", 32'(busy), 32'(0));
    end
    rst_n = 1'b1;
    q_m = 8'h00; rr_m = 1'b0;
    run_txn(1'b1, 2'b10, 3'd6, 4'd0, 1'b0, 2'b00, 3'd0, 4'd0, 0, 8'h40);

    // Randomized transactions against the model.
    for (int t = 0; t < 60; t++) begin
      v0 = 1'($urandom_range(0, 1)); v1 = 1'($urandom_range(0, 1));
      c0 = 2'($urandom_range(0, 3)); c1 = 2'($urandom_range(0, 3));
      i0 = 3'($urandom_range(0, 7)); i1 = 3'($urandom_range(0, 7));
      n0 = 4'($urandom_range(0, 15)); n1 = 4'($urandom_range(0, 15));
      if (v0 && v1)  w = int'(rr_m);
      else if (v0)   w = 0;
      else if (v1)   w = 1;
      else           w = -1;
      if (w == 0)      eq = jk_model(q_m, c0, i0, n0);
      else if (w == 1) eq = jk_model(q_m, c1, i1, n1);
      else             eq = q_m;
      run_txn(v0, c0, i0, n0, v1, c1, i1, n1, w, eq);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
